mv_column_scheduler: RTL and testbench
======================================

// Module: mv_column_scheduler
// PURPOSE
//  Sequences one column-wise matrix-vector product y = M*x through the PE column datapath.
//  Latches a 16-column matrix and a 16-element vector on a start handshake.
//  Issues one (column, x[j]) pair per accepted beat under valid/ready flow control.
//  Waits for the PE accumulator to confirm completion, then pulses done.
// PARAMETERS
//  NCOL    16   number of columns per matrix (and elements per vector); power of 2, >=2
//  COL_W   256  bits per column (NCOL elements x ELEM_W)
//  ELEM_W  16   bits per signed vector element
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous, active-high reset
//  start      in   1            request to begin a product; sampled with start_rdy
//  start_rdy  out  1            high only in IDLE
//  matrix     in   NCOL*COL_W   column 0 at MSBs [NCOL*COL_W-1 -: COL_W], column NCOL-1 at LSBs
//  vec        in   NCOL*ELEM_W  x[0] at MSBs, x[NCOL-1] at LSBs, signed
//  abort      in   1            cancel current product
//  out_valid  out  1            column beat valid
//  out_ready  in   1            PE accepts beat when out_valid & out_ready
//  out_col    out  COL_W        selected column data
//  out_x      out  ELEM_W       selected vector element x[idx]
//  out_idx    out  log2(NCOL)   current column index
//  out_first  out  1            beat is column 0 (PE clears accumulator)
//  out_last   out  1            beat is column NCOL-1
//  acc_done   in   1            PE pulse: final accumulation written
//  busy       out  1            high in every state except IDLE
//  done       out  1            one-cycle pulse, product complete
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, out_valid=0, done=0, busy=0, start_rdy=1; out_col/out_x/out_idx=0.
//  States: IDLE -> ISSUE -> WAIT_ACC -> DONE -> IDLE.
//  IDLE: start & start_rdy latches matrix and vec into internal regs, idx<=0, -> ISSUE next cycle.
//  ISSUE: out_valid=1; out_col/out_x/out_idx driven from registers of current idx.
//   Outputs are registered; first beat is valid the cycle after the start handshake (latency 1).
//   Payload held stable while out_valid & !out_ready.
//   On handshake with idx<NCOL-1: idx<=idx+1, next payload valid the following cycle (no bubble).
//   On handshake with idx==NCOL-1: out_valid<=0, -> WAIT_ACC. Exactly NCOL beats per product.
//  WAIT_ACC: out_valid=0; acc_done -> DONE. acc_done outside WAIT_ACC is ignored.
//  DONE: done=1 for exactly one cycle, -> IDLE. start is not accepted in DONE.
//  out_first = (idx==0) & out_valid; out_last = (idx==NCOL-1) & out_valid.
//  Matrix/vec inputs are ignored after the latch; changing them mid-product has no effect.
//  abort in any non-IDLE state: -> IDLE next cycle, out_valid=0, idx=0, no done pulse.
//   abort beats a simultaneous handshake or acc_done; abort in IDLE is ignored.
//  rst mid-operation: identical to reset values next cycle; rst beats abort and start.
//  No arithmetic on data; idx wraps to 0 only via IDLE, never by overflow.
// TESTING
//  1 Reset then start with col j = {16{16'(j)}}, vec x[j]=j+1, out_ready=1
//    -> 16 beats on consecutive cycles, out_idx 0..15, out_x 1..16, first@0, last@15.
//  2 Same as 1 with out_ready toggling 1,0,1,0
//    -> each beat held stable while stalled, 16 beats total, no skipped or duplicated idx.
//  3 After the last beat, hold acc_done=0 for 5 cycles, then pulse it
//    -> busy=1, out_valid=0 throughout; done=1 exactly one cycle after acc_done; start_rdy=1 next cycle.
//  4 Abort asserted at idx=7 with out_ready=1
//    -> no beat 8, out_valid=0 next cycle, no done, start_rdy=1; new start restarts at idx 0.
//  5 Change matrix/vec inputs during ISSUE
//    -> issued data still matches values latched at start.
//  6 Assert rst at idx=10 simultaneously with start and abort
//    -> all outputs at reset values next cycle; start ignored.

Source files
------------

// File: rtl/mv_column_scheduler.sv
// Column-wise matrix-vector product sequencer: latches a matrix and vector on start,
// streams one (column, x[j]) beat per handshake, then waits for the PE to confirm completion.
module mv_column_scheduler #(
  parameter int NCOL   = 16,
  parameter int COL_W  = 256,
  parameter int ELEM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     start_rdy,
  input  logic [NCOL*COL_W-1:0]    matrix,
  input  logic [NCOL*ELEM_W-1:0]   vec,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COL_W-1:0]         out_col,
  output logic signed [ELEM_W-1:0] out_x,
  output logic [$clog2(NCOL)-1:0]  out_idx,
  output logic                     out_first,
  output logic                     out_last,
  input  logic                     acc_done,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = $clog2(NCOL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       out_valid_q, out_valid_d;
  logic [COL_W-1:0]           out_col_q, out_col_d;
  logic signed [ELEM_W-1:0]   out_x_q, out_x_d;
  logic                       done_q, done_d;
  logic [NCOL*COL_W-1:0]      mat_q, mat_d;
  logic [NCOL*ELEM_W-1:0]     vec_q, vec_d;

  // Column 0 sits at the MSBs, so index k counts down from the top of the bus.
  function automatic logic [COL_W-1:0] col_of(input logic [NCOL*COL_W-1:0] m,
                                               input logic [IDX_W-1:0] k);
    col_of = m[(NCOL-1-int'(k))*COL_W +: COL_W];
  endfunction

  function automatic logic signed [ELEM_W-1:0] elem_of(input logic [NCOL*ELEM_W-1:0] v,
                                                       input logic [IDX_W-1:0] k);
    elem_of = v[(NCOL-1-int'(k))*ELEM_W +: ELEM_W];
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_x_d     = out_x_q;
    done_d      = 1'b0;
    mat_d       = mat_q;
    vec_d       = vec_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The first beat is loaded straight from the inputs so it is valid next cycle.
          mat_d       = matrix;
          vec_d       = vec;
          idx_d       = '0;
          out_col_d   = col_of(matrix, '0);
          out_x_d     = elem_of(vec, '0);
          out_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            state_d     = S_WAIT_ACC;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            out_col_d = col_of(mat_q, idx_q + IDX_W'(1));
            out_x_d   = elem_of(vec_q, idx_q + IDX_W'(1));
          end
        end
      end
      S_WAIT_ACC: begin
        if (acc_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any handshake or completion seen in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      out_col_d   = '0;
      out_x_d     = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_x_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_x_q     <= out_x_d;
      done_q      <= done_d;
    end
  end

  // Operand storage carries data only; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
    vec_q <= vec_d;
  end

  assign start_rdy = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_x     = out_x_q;
  assign out_idx   = idx_q;
  assign out_first = out_valid_q && (idx_q == '0);
  assign out_last  = out_valid_q && (idx_q == LAST_IDX);
  assign done      = done_q;

endmodule

// File: tb/tb_mv_column_scheduler.sv
// Directed bench for mv_column_scheduler: streaming, stalls, completion wait, abort, input isolation, reset.
module tb_mv_column_scheduler;
  localparam int NCOL   = 16;
  localparam int COL_W  = 256;
  localparam int ELEM_W = 16;

  logic                    clk = 1'b0;
  logic                    rst, start, abort, out_ready, acc_done;
  logic [NCOL*COL_W-1:0]   matrix;
  logic [NCOL*ELEM_W-1:0]  vec;
  logic                    start_rdy, out_valid, out_first, out_last, busy, done;
  logic [COL_W-1:0]        out_col;
  logic signed [ELEM_W-1:0] out_x;
  logic [3:0]              out_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mv_column_scheduler #(.NCOL(NCOL), .COL_W(COL_W), .ELEM_W(ELEM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_rdy(start_rdy),
    .matrix(matrix), .vec(vec), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_x(out_x), .out_idx(out_idx), .out_first(out_first), .out_last(out_last),
    .acc_done(acc_done), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [COL_W-1:0] got, input logic [COL_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COL_W-1:0] col_pat(input int j);
    logic [COL_W-1:0] c;
    for (int e = 0; e < NCOL; e++) c[e*ELEM_W +: ELEM_W] = 16'(j);
    return c;
  endfunction

  task automatic load_operands();
    for (int j = 0; j < NCOL; j++) begin
      matrix[(NCOL-1-j)*COL_W +: COL_W] = col_pat(j);
      vec[(NCOL-1-j)*ELEM_W +: ELEM_W]  = 16'(j + 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, COL_W'(out_valid), 0);
    check({tag, "_done"},  COL_W'(done), 0);
    check({tag, "_busy"},  COL_W'(busy), 0);
    check({tag, "_rdy"},   COL_W'(start_rdy), 1);
    check({tag, "_idx"},   COL_W'(out_idx), 0);
    check({tag, "_col"},   out_col, 0);
    check({tag, "_x"},     COL_W'(out_x), 0);
  endtask

  task automatic check_beat(input string tag, input int k);
    check({tag, "_valid"}, COL_W'(out_valid), 1);
    check({tag, "_idx"},   COL_W'(out_idx), COL_W'(k));
    check({tag, "_x"},     COL_W'(out_x), COL_W'(k + 1));
    check({tag, "_col"},   out_col, col_pat(k));
    check({tag, "_first"}, COL_W'(out_first), COL_W'(k == 0));
    check({tag, "_last"},  COL_W'(out_last), COL_W'(k == NCOL - 1));
  endtask

  task automatic finish_acc(input string tag);
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    check({tag, "_done_hi"}, COL_W'(done), 1);
    check({tag, "_rdy_in_done"}, COL_W'(start_rdy), 0);
    step();
    check({tag, "_done_lo"}, COL_W'(done), 0);
    check({tag, "_rdy_after"}, COL_W'(start_rdy), 1);
  endtask

  initial begin
    int e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; acc_done = 1'b0;
    matrix = '0; vec = '0;
    load_operands();
    step();
    step();
    check_reset_vals("rst");

    // Test 1: full-rate streaming
    rst = 1'b0; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < NCOL; k++) begin
      check_beat("t1", k);
      step();
    end
    check("t1_valid_end", COL_W'(out_valid), 0);

    // Test 3: hold in WAIT_ACC, acc_done is the only way out
    for (int c = 0; c < 5; c++) begin
      check("t3_busy", COL_W'(busy), 1);
      check("t3_valid", COL_W'(out_valid), 0);
      check("t3_done", COL_W'(done), 0);
      step();
    end
    finish_acc("t3");

    // Tests 2 and 5: alternating ready, operand inputs scrambled after the latch
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    matrix = '1;
    vec = '0;
    e = 0;
    for (int c = 0; c < 4 * NCOL && e < NCOL; c++) begin
      out_ready = (c % 2 == 0);
      check_beat("t2", e);
      step();
      if (out_ready) e++;
    end
    check("t2_beats", COL_W'(e), COL_W'(NCOL));
    check("t2_valid_end", COL_W'(out_valid), 0);
    out_ready = 1'b0;
    step();
    check("t2_ignore_ready_wait", COL_W'(busy), 1);
    finish_acc("t2");
    load_operands();

    // Test 4: abort at idx 7 beats the handshake
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) step();
    check_beat("t4_at7", 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_valid", COL_W'(out_valid), 0);
    check("t4_idx", COL_W'(out_idx), 0);
    check("t4_rdy", COL_W'(start_rdy), 1);
    check("t4_busy", COL_W'(busy), 0);
    for (int c = 0; c < 3; c++) begin
      acc_done = 1'b1;
      step();
      check("t4_no_done", COL_W'(done), 0);
      check("t4_no_valid", COL_W'(out_valid), 0);
    end
    acc_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_beat("t4_restart", 0);

    // Test 6: reset at idx 10 wins over start and abort
    for (int k = 0; k < 10; k++) step();
    check_beat("t6_at10", 10);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    check_reset_vals("t6");
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    step();
    check("t6_still_idle", COL_W'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
